// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: state encoding and register indices.
package pipeline_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] RUN      = 2'd0;
    localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
    localparam logic [STATE_W-1:0] DRAIN    = 2'd2;
    localparam logic [STATE_W-1:0] HALTED   = 2'd3;

    // x0 is hardwired to zero, so a load "writing" it never creates a hazard
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-facing bundle: hazard inputs from the stage registers and the
// write-enable / flush controls driven back into them.
interface pipeline_hazard_ctrl_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       mem_branch_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       halt_req;

    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_flush;
    logic       pipe_hold;

    // pipeline datapath side
    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, dmem_req, dmem_ready, halt_req,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold
    );

    // hazard controller side
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               mem_branch_taken, dmem_req, dmem_ready, halt_req,
        output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use detector: the ID instruction needs a register the EX-stage load has not fetched yet.
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd,
    input  logic       ex_mem_read,
    output logic       hazard
);

    // rs2 only matters when the instruction actually reads it (I/U/J types carry immediate bits there)
    always_comb begin
        hazard = ex_mem_read && (ex_rd != REG_X0) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory hold, branch flush,
// halt/drain and load-use bubbles, with saturating event counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_W        = 32
) (
    input  logic                clk,
    input  logic                reset,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                halted,
    output logic                mem_err,
    output logic [STATE_W-1:0]  state,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    wait_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(MEM_TIMEOUT - 1);

    logic [DW-1:0] drain_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          hazard;
    logic          run_like, hold, do_flush, do_halt, do_stall, tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    load_use_detect u_lud (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_uses_rs2 (hz.id_uses_rs2),
        .ex_rd       (hz.ex_rd),
        .ex_mem_read (hz.ex_mem_read),
        .hazard      (hazard)
    );

    // Decide this cycle's action; MEM_WAIT without a hold is the release cycle and behaves like RUN
    always_comb begin
        run_like = (state == RUN) || (state == MEM_WAIT);
        hold     = hz.dmem_req && !hz.dmem_ready && (state != HALTED);
        do_flush = run_like && !hold && hz.mem_branch_taken;
        do_halt  = run_like && !hold && !hz.mem_branch_taken && hz.halt_req;
        do_stall = run_like && !hold && !hz.mem_branch_taken && !hz.halt_req && hazard;
        tmo_hit  = hold && (tmo_cnt == TMO_LAST);
    end

    // Stage controls, highest-priority condition wins
    always_comb begin
        hz.pc_write    = 1'b1;
        hz.ifid_write  = 1'b1;
        hz.ifid_flush  = 1'b0;
        hz.idex_bubble = 1'b0;
        hz.exmem_flush = 1'b0;
        hz.pipe_hold   = 1'b0;
        if (reset || state == HALTED) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (hold) begin
            hz.pc_write   = 1'b0;
            hz.ifid_write = 1'b0;
            hz.pipe_hold  = 1'b1;
        end else if (state == DRAIN) begin
            hz.pc_write   = 1'b0;
            hz.ifid_flush = 1'b1;
        end else if (do_flush) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
            hz.exmem_flush = 1'b1;
        end else if (do_stall) begin
            hz.pc_write    = 1'b0;
            hz.ifid_write  = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    assign halted = (state == HALTED);

    // State, drain/timeout counters, sticky error and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            tmo_cnt   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
            wait_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            tmo_cnt <= hold ? tmo_cnt + 1'b1 : '0;
            if (hold) begin
                wait_cnt <= sat_inc(wait_cnt);
                if (tmo_hit) begin
                    mem_err <= 1'b1;
                    state   <= HALTED;
                end else if (state == RUN) begin
                    state <= MEM_WAIT;
                end
                // DRAIN keeps its state and frozen drain count
            end else begin
                case (state)
                    DRAIN: begin
                        if (drain_cnt == DRAIN_LAST) state <= HALTED;
                        else                         drain_cnt <= drain_cnt + 1'b1;
                    end
                    RUN, MEM_WAIT: begin
                        state <= RUN;
                        if (do_flush) begin
                            flush_cnt <= sat_inc(flush_cnt);
                        end else if (do_halt) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end else if (do_stall) begin
                            stall_cnt <= sat_inc(stall_cnt);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
